core_immencode: RTL and testbench
=================================

# core_immencode

Pipelined immediate encoder: the inverse of the core immediate extender. It takes a 64-bit immediate, an immediate-format code and a 32-bit instruction template, and scatters the immediate into the template's instruction bits [31:7] for that format. It checks that the immediate is representable in the format and keeps a saturating error count. It sits in the debug/boot program-patch path, ahead of instruction-memory writes, and patches branch/jump offsets and constants into instruction words.

## Interface
Parameters:
- CNT_W, 16, width of the saturating error counter.

Ports:
- i_immencode_clk  in  1  clock; all state updates on the rising edge.
- i_immencode_rst  in  1  synchronous, active-high reset.
- i_immencode_valid  in  1  input beat valid.
- o_immencode_ready  out  1  block can accept an input beat.
- i_immencode_imm  in  64  immediate to encode.
- i_immencode_immsrc  in  3  format code; same encoding as the extender's immsrc.
- i_immencode_tmpl  in  32  instruction template; its bits outside the format's immediate field pass through unchanged.
- o_immencode_valid  out  1  output beat valid.
- i_immencode_ready  in  1  downstream accepts the output beat.
- o_immencode_instr  out  32  encoded instruction.
- o_immencode_err  out  1  the immediate was not representable or the format code is invalid; qualified by o_immencode_valid.
- i_immencode_cntclr  in  1  clears the error counter.
- o_immencode_errcnt  out  CNT_W  saturating count of errored beats that have been delivered.

## Operation
Bit placement by format. Bits not listed come from the template. Each format's range rule must hold, otherwise err=1 and the bits are still packed from the low immediate bits.
- 000 I: instr[31:20]=imm[11:0]. Range: imm[63:11] all equal.
- 001 S: instr[31:25]=imm[11:5]; instr[11:7]=imm[4:0]. Range: same as I.
- 010 B: instr[31]=imm[12]; [7]=imm[11]; [30:25]=imm[10:5]; [11:8]=imm[4:1]. Range: imm[63:12] all equal, and imm[0]=0.
- 011 J: instr[31]=imm[20]; [19:12]=imm[19:12]; [20]=imm[11]; [30:21]=imm[10:1]. Range: imm[63:20] all equal, and imm[0]=0.
- 100 U: instr[31:12]=imm[31:12]. Range: imm[63:31] all equal, and imm[11:0]=0.
- 101 A: no immediate bits; instr = template. Range: imm must equal 0.
- 110 Z: instr[19:15]=imm[4:0]. Range: imm[63:5]=0.
- 111: invalid; instr = template, err=1.

Pipeline:
- Stage 1 registers imm, immsrc and tmpl, and computes the range-check result.
- Stage 2 registers the packed instruction and err; it drives the outputs.

Handshake:
- A transfer occurs on an edge where valid and ready are both high.
- Stage 2 advances when its valid bit is clear or i_immencode_ready is high.
- Stage 1 advances when its valid bit is clear or stage 2 advances.
- o_immencode_ready equals the stage-1 advance condition.
- Full throughput: one beat per cycle with no bubbles under continuous ready.
- While o_immencode_valid is high and i_immencode_ready is low, o_immencode_instr and o_immencode_err hold stable.

Error counter:
- Increments by 1 on each output transfer with err=1.
- Saturates at all-ones and never wraps.
- i_immencode_cntclr forces the counter to 0. It wins over a simultaneous increment.

## Timing
- Reset: both stage valid bits, o_immencode_valid, o_immencode_instr, o_immencode_err and o_immencode_errcnt are 0; o_immencode_ready is 1 in the first cycle after reset.
- Reset asserted mid-operation discards all in-flight beats on that edge; no partial output appears.
- Latency is 2 cycles: a beat accepted at edge N is presented on o_immencode_valid after edge N+1, when downstream is ready.
- With i_immencode_ready held low, the pipeline absorbs exactly 2 beats, then o_immencode_ready drops combinationally.
- When i_immencode_ready rises, o_immencode_ready rises in the same cycle (combinational path from i_immencode_ready).
- There is no combinational path from input data to outputs.

## Test plan
- I format, imm=0xFFFF_FFFF_FFFF_FFFF, tmpl=0x0000_0013 -> instr 0xFFF0_0013, err 0, valid 2 cycles after accept.
- B format, imm=0x800, tmpl=0x0000_0063 -> instr 0x0000_00E3, err 0; then B format, imm=0x1001 -> err 1, errcnt=1.
- U format, imm=0x1234_5000, tmpl=0x0000_0037 -> instr 0x1234_5037; J format, imm=-2, tmpl=0x0000_006F -> instr 0xFFFF_F06F; J format, imm=0x10_0000 -> err 1.
- Backpressure: stream 5 beats with i_immencode_ready low for 4 cycles -> exactly 2 beats accepted, o_immencode_ready=0, held output stable; release ready -> all 5 beats delivered in order, none lost or duplicated.
- Counter: force errcnt to 0xFFFF via 65535 errored beats -> one more errored beat leaves 0xFFFF; cntclr together with an errored transfer -> 0.
- Reset with 2 beats in flight -> o_immencode_valid=0 next cycle and errcnt=0; immsrc=111 afterwards -> instr=tmpl, err=1.

Source files
------------

// File: rtl/core_immencode.sv
// Purpose: scatter a 64-bit immediate into instruction bits [31:7] of a template per format; flag unrepresentable values.
// Latency: 2 cycles (stage 1 holds the operands, stage 2 holds the packed word); one beat per cycle under continuous ready.
// Backpressure: valid/ready; o_immencode_ready is combinational from i_immencode_ready, and the pipe absorbs 2 beats while stalled.
//
// Ports:
//   i_immencode_clk / i_immencode_rst   clock, synchronous active-high reset
//   i_immencode_valid / o_immencode_ready   input handshake
//   i_immencode_imm, _immsrc, _tmpl     immediate, format code, instruction template
//   o_immencode_valid / i_immencode_ready   output handshake
//   o_immencode_instr, o_immencode_err  packed instruction, representability error
//   i_immencode_cntclr, o_immencode_errcnt  clear and value of the saturating delivered-error count
module core_immencode #(
    parameter int CNT_W = 16
) (
    input  logic             i_immencode_clk,
    input  logic             i_immencode_rst,
    input  logic             i_immencode_valid,
    output logic             o_immencode_ready,
    input  logic [63:0]      i_immencode_imm,
    input  logic [2:0]       i_immencode_immsrc,
    input  logic [31:0]      i_immencode_tmpl,
    output logic             o_immencode_valid,
    input  logic             i_immencode_ready,
    output logic [31:0]      o_immencode_instr,
    output logic             o_immencode_err,
    input  logic             i_immencode_cntclr,
    output logic [CNT_W-1:0] o_immencode_errcnt
);

    // Stage 1 operand registers
    logic             s1_vld_q, s1_vld_d;
    logic [63:0]      s1_imm_q, s1_imm_d;
    logic [2:0]       s1_src_q, s1_src_d;
    logic [31:0]      s1_tmpl_q, s1_tmpl_d;

    // Stage 2 result registers
    logic             s2_vld_q, s2_vld_d;
    logic [31:0]      s2_instr_q, s2_instr_d;
    logic             s2_err_q, s2_err_d;

    logic [CNT_W-1:0] errcnt_q, errcnt_d;

    logic             s1_adv, s2_adv, out_xfer;
    logic [31:0]      pack_instr;
    logic             pack_err;
    logic             ok_12, ok_13, ok_21, ok_32;

    // Handshake: a stage may load when it is empty or its contents move on this edge.
    always_comb begin
        s2_adv   = !s2_vld_q || i_immencode_ready;
        s1_adv   = !s1_vld_q || s2_adv;
        out_xfer = s2_vld_q && i_immencode_ready;
    end

    // Sign-extension checks: all bits from the field's sign position upward must agree.
    always_comb begin
        ok_12 = (&s1_imm_q[63:11]) || !(|s1_imm_q[63:11]);
        ok_13 = (&s1_imm_q[63:12]) || !(|s1_imm_q[63:12]);
        ok_21 = (&s1_imm_q[63:20]) || !(|s1_imm_q[63:20]);
        ok_32 = (&s1_imm_q[63:31]) || !(|s1_imm_q[63:31]);
    end

    // Bit scatter; the low immediate bits are packed even when the range check fails.
    always_comb begin
        pack_instr = s1_tmpl_q;
        pack_err   = 1'b0;
        case (s1_src_q)
            3'b000: begin
                pack_instr[31:20] = s1_imm_q[11:0];
                pack_err          = !ok_12;
            end
            3'b001: begin
                pack_instr[31:25] = s1_imm_q[11:5];
                pack_instr[11:7]  = s1_imm_q[4:0];
                pack_err          = !ok_12;
            end
            3'b010: begin
                pack_instr[31]    = s1_imm_q[12];
                pack_instr[7]     = s1_imm_q[11];
                pack_instr[30:25] = s1_imm_q[10:5];
                pack_instr[11:8]  = s1_imm_q[4:1];
                pack_err          = !ok_13 || s1_imm_q[0];
            end
            3'b011: begin
                pack_instr[31]    = s1_imm_q[20];
                pack_instr[19:12] = s1_imm_q[19:12];
                pack_instr[20]    = s1_imm_q[11];
                pack_instr[30:21] = s1_imm_q[10:1];
                pack_err          = !ok_21 || s1_imm_q[0];
            end
            3'b100: begin
                pack_instr[31:12] = s1_imm_q[31:12];
                pack_err          = !ok_32 || (|s1_imm_q[11:0]);
            end
            3'b101: begin
                pack_err = |s1_imm_q;
            end
            3'b110: begin
                pack_instr[19:15] = s1_imm_q[4:0];
                pack_err          = |s1_imm_q[63:5];
            end
            default: begin
                pack_err = 1'b1;
            end
        endcase
    end

    // Next-state for both stages and the error counter.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_tmpl_d  = s1_tmpl_q;
        s2_vld_d   = s2_vld_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        errcnt_d   = errcnt_q;

        if (s1_adv) begin
            s1_vld_d  = i_immencode_valid;
            s1_imm_d  = i_immencode_imm;
            s1_src_d  = i_immencode_immsrc;
            s1_tmpl_d = i_immencode_tmpl;
        end

        // Stage 2 only reloads when it advances, so a stalled output holds still.
        if (s2_adv) begin
            s2_vld_d   = s1_vld_q;
            s2_instr_d = pack_instr;
            s2_err_d   = pack_err;
        end

        // Clear has priority over a coincident errored delivery.
        if (i_immencode_cntclr) begin
            errcnt_d = '0;
        end else if (out_xfer && s2_err_q && (errcnt_q != {CNT_W{1'b1}})) begin
            errcnt_d = errcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_immencode_clk) begin
        if (i_immencode_rst) begin
            s1_vld_q   <= 1'b0;
            s1_imm_q   <= '0;
            s1_src_q   <= '0;
            s1_tmpl_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_imm_q   <= s1_imm_d;
            s1_src_q   <= s1_src_d;
            s1_tmpl_q  <= s1_tmpl_d;
            s2_vld_q   <= s2_vld_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            errcnt_q   <= errcnt_d;
        end
    end

    assign o_immencode_ready  = s1_adv;
    assign o_immencode_valid  = s2_vld_q;
    assign o_immencode_instr  = s2_instr_q;
    assign o_immencode_err    = s2_err_q;
    assign o_immencode_errcnt = errcnt_q;

endmodule

// File: tb/tb_core_immencode.sv
// Purpose: self-checking bench for core_immencode against a format-rule reference model.
// Latency: inputs change on the falling edge, outputs are observed on the falling edge after each rising edge.
// Backpressure: downstream ready is driven directly, both held low and randomised.
module tb_core_immencode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] in_imm;
    logic [2:0]  in_src;
    logic [31:0] in_tmpl;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_instr;
    logic        out_err;
    logic        cntclr;
    logic [15:0] errcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_immencode #(.CNT_W(16)) dut (
        .i_immencode_clk    (clk),
        .i_immencode_rst    (rst),
        .i_immencode_valid  (in_vld),
        .o_immencode_ready  (in_rdy),
        .i_immencode_imm    (in_imm),
        .i_immencode_immsrc (in_src),
        .i_immencode_tmpl   (in_tmpl),
        .o_immencode_valid  (out_vld),
        .i_immencode_ready  (out_rdy),
        .o_immencode_instr  (out_instr),
        .o_immencode_err    (out_err),
        .i_immencode_cntclr (cntclr),
        .o_immencode_errcnt (errcnt)
    );

    // Reference: representability as signed integer ranges, placement as listed per format.
    function automatic logic [32:0] ref_encode(input logic [63:0] imm, input logic [2:0] src,
                                               input logic [31:0] tmpl);
        longint      s;
        logic [31:0] w;
        logic        e;
        s = longint'(imm);
        w = tmpl;
        e = 1'b0;
        case (src)
            3'd0: begin w[31:20] = imm[11:0]; e = !(s >= -2048 && s <= 2047); end
            3'd1: begin w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; e = !(s >= -2048 && s <= 2047); end
            3'd2: begin
                w[31] = imm[12]; w[7] = imm[11]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1];
                e = !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
            end
            3'd3: begin
                w[31] = imm[20]; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
                e = !(s >= -(longint'(1) << 20) && s < (longint'(1) << 20)) || (imm % 2 != 0);
            end
            3'd4: begin
                w[31:12] = imm[31:12];
                e = !(s >= -(longint'(1) << 31) && s < (longint'(1) << 31)) || (imm % 4096 != 0);
            end
            3'd5: e = (imm != 0);
            3'd6: begin w[19:15] = imm[4:0]; e = (imm > 31); end
            default: e = 1'b1;
        endcase
        return {w, e};
    endfunction

    // Mix of full-width values, sign-extended narrow values, aligned values and tiny values.
    function automatic logic [63:0] rand_imm();
        logic [63:0] r;
        longint      s;
        int          w;
        r = {$urandom, $urandom};
        case ($urandom % 4)
            0: ;
            1, 2: begin
                w = $urandom_range(1, 40);
                s = longint'(r << (64 - w));
                r = 64'(s >>> (64 - w));
            end
            default: r = 64'($urandom % 64);
        endcase
        if ($urandom % 2 == 0) r[0] = 1'b0;
        if ($urandom % 4 == 0) r[11:0] = 12'h0;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [63:0] imm, input logic [2:0] src,
                         input logic [31:0] tmpl);
        in_vld  = v;
        in_imm  = imm;
        in_src  = src;
        in_tmpl = tmpl;
    endtask

    task automatic test_reset();
        rst = 1'b1; cntclr = 1'b0; out_rdy = 1'b0;
        drive(1'b0, 64'h0, 3'd0, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_vld); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", out_err); end
        checks++; if (errcnt !== 16'h0) begin errors++; $display("FAIL reset_errcnt: got %h expected 0", errcnt); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_rdy); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [63:0] v_imm[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h800, 64'h1001, 64'h1234_5000,
                                   64'hFFFF_FFFF_FFFF_FFFE, 64'h10_0000};
        logic [2:0]  v_src[6]  = '{3'd0, 3'd2, 3'd2, 3'd4, 3'd3, 3'd3};
        logic [31:0] v_tmpl[6] = '{32'h13, 32'h63, 32'h63, 32'h37, 32'h6F, 32'h6F};
        logic [31:0] v_exp[6]  = '{32'hFFF0_0013, 32'h0000_00E3, 32'h8000_0063, 32'h1234_5037,
                                   32'hFFFF_F06F, 32'h8000_006F};
        logic        v_err[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] exp_cnt = 16'h0;
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, v_imm[i], v_src[i], v_tmpl[i]);
            @(negedge clk);
            drive(1'b0, 64'h0, 3'd0, 32'h0);
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, out_vld); end
            @(negedge clk);
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b expected 1", i, out_vld); end
            checks++; if (out_instr !== v_exp[i]) begin errors++; $display("FAIL dir%0d_instr: got %h expected %h", i, out_instr, v_exp[i]); end
            checks++; if (out_err !== v_err[i]) begin errors++; $display("FAIL dir%0d_err: got %b expected %b", i, out_err, v_err[i]); end
            @(negedge clk);
            if (v_err[i]) exp_cnt++;
            checks++; if (errcnt !== exp_cnt) begin errors++; $display("FAIL dir%0d_errcnt: got %h expected %h", i, errcnt, exp_cnt); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] b_imm[5];
        logic [2:0]  b_src[5];
        logic [31:0] b_tmpl[5];
        logic [32:0] q[$];
        logic [32:0] held, e;
        int          acc = 0;
        int          got = 0;
        for (int i = 0; i < 5; i++) begin
            b_imm[i] = rand_imm(); b_src[i] = 3'($urandom % 8); b_tmpl[i] = $urandom;
        end
        out_rdy = 1'b0;
        held = '0;
        for (int k = 0; k < 4; k++) begin
            drive(acc < 5, b_imm[acc % 5], b_src[acc % 5], b_tmpl[acc % 5]);
            #1;
            if (k == 2) held = {out_instr, out_err};
            if (k == 3) begin
                checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", in_rdy); end
                checks++; if (acc !== 2) begin errors++; $display("FAIL bp_absorbed: got %0d expected 2", acc); end
                checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_vld); end
                checks++; if ({out_instr, out_err} !== held) begin errors++; $display("FAIL bp_hold: got %h expected %h", {out_instr, out_err}, held); end
                checks++; if ({out_instr, out_err} !== q[0]) begin errors++; $display("FAIL bp_head: got %h expected %h", {out_instr, out_err}, q[0]); end
            end
            if (in_vld && in_rdy) begin q.push_back(ref_encode(b_imm[acc], b_src[acc], b_tmpl[acc])); acc++; end
            @(negedge clk);
        end
        for (int c = 0; c < 30 && got < 5; c++) begin
            drive(acc < 5, b_imm[acc % 5], b_src[acc % 5], b_tmpl[acc % 5]);
            out_rdy = 1'b1;
            #1;
            if (c == 0) begin
                checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b expected 1", in_rdy); end
            end
            if (out_vld && out_rdy) begin
                e = (q.size() > 0) ? q.pop_front() : 33'h0;
                checks++; if ({out_instr, out_err} !== e) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", got, {out_instr, out_err}, e); end
                got++;
            end
            if (in_vld && in_rdy) begin q.push_back(ref_encode(b_imm[acc], b_src[acc], b_tmpl[acc])); acc++; end
            @(negedge clk);
        end
        drive(1'b0, 64'h0, 3'd0, 32'h0);
        #1;
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_delivered: got %0d expected 5", got); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_vld); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        logic [32:0] e;
        logic [63:0] imm;
        logic [2:0]  src;
        logic [31:0] tmpl;
        logic [15:0] exp_cnt = 16'h0;
        int          sent = 0;
        int          got = 0;
        cntclr = 1'b1;
        @(negedge clk);
        cntclr = 1'b0;
        for (int c = 0; c < 3000 && got < 400; c++) begin
            imm = rand_imm(); src = 3'($urandom % 8); tmpl = $urandom;
            drive((sent < 400) && ($urandom % 4 != 0), imm, src, tmpl);
            out_rdy = ($urandom % 4 != 0);
            #1;
            checks++; if (errcnt !== exp_cnt) begin errors++; $display("FAIL rnd_errcnt: got %h expected %h", errcnt, exp_cnt); end
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL rnd_spurious: got output %h expected none", out_instr);
                end else begin
                    e = q.pop_front();
                    checks++; if ({out_instr, out_err} !== e) begin errors++; $display("FAIL rnd_beat%0d: got %h expected %h", got, {out_instr, out_err}, e); end
                    if (e[0]) exp_cnt++;
                end
                got++;
            end
            if (in_vld && in_rdy) begin q.push_back(ref_encode(imm, src, tmpl)); sent++; end
            @(negedge clk);
        end
        drive(1'b0, 64'h0, 3'd0, 32'h0);
        checks++; if (got !== 400) begin errors++; $display("FAIL rnd_count: got %0d expected 400", got); end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] tmpl;
        out_rdy = 1'b1;
        cntclr = 1'b1; @(negedge clk); cntclr = 1'b0;
        drive(1'b1, 64'h0, 3'd7, 32'h0); @(negedge clk);
        drive(1'b0, 64'h0, 3'd0, 32'h0); @(negedge clk); @(negedge clk);
        checks++; if (errcnt !== 16'h1) begin errors++; $display("FAIL rst_pre_errcnt: got %h expected 1", errcnt); end
        out_rdy = 1'b0;
        drive(1'b1, 64'h5, 3'd0, 32'h13); @(negedge clk);
        drive(1'b1, 64'h6, 3'd0, 32'h13); @(negedge clk);
        drive(1'b0, 64'h0, 3'd0, 32'h0);
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rst_inflight: got %b expected 1", out_vld); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_vld); end
        checks++; if (errcnt !== 16'h0) begin errors++; $display("FAIL rst_mid_errcnt: got %h expected 0", errcnt); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_mid_instr: got %h expected 0", out_instr); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_rdy); end
        out_rdy = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_no_leak: got %b expected 0", out_vld); end
        tmpl = $urandom;
        drive(1'b1, rand_imm(), 3'd7, tmpl); @(negedge clk);
        drive(1'b0, 64'h0, 3'd0, 32'h0); @(negedge clk);
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL inv_valid: got %b expected 1", out_vld); end
        checks++; if (out_instr !== tmpl) begin errors++; $display("FAIL inv_instr: got %h expected %h", out_instr, tmpl); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL inv_err: got %b expected 1", out_err); end
        @(negedge clk);
    endtask

    task automatic test_counter_sat();
        out_rdy = 1'b1;
        cntclr = 1'b1; @(negedge clk); cntclr = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            drive(i < 65535, 64'h0, 3'd7, 32'h0);
            @(negedge clk);
        end
        checks++; if (errcnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", errcnt); end
        drive(1'b1, 64'h1, 3'd5, 32'h0); @(negedge clk);
        drive(1'b0, 64'h0, 3'd0, 32'h0); @(negedge clk); @(negedge clk); @(negedge clk);
        checks++; if (errcnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", errcnt); end
        drive(1'b1, 64'h0, 3'd7, 32'h0); @(negedge clk);
        drive(1'b0, 64'h0, 3'd0, 32'h0); @(negedge clk);
        checks++; if ({out_vld, out_err} !== 2'b11) begin errors++; $display("FAIL clr_setup: got %b expected 11", {out_vld, out_err}); end
        cntclr = 1'b1; @(negedge clk); cntclr = 1'b0;
        checks++; if (errcnt !== 16'h0) begin errors++; $display("FAIL clr_wins: got %h expected 0", errcnt); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_inflight();
        test_counter_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
